// File: rtl/mesh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesh_pkg
// Description : Shared packet layout, packet struct and destination check for
//               the mesh_gnrtr router mesh, its terminal FIFOs and benches.
// Revision    : 1.0 - initial release
// ============================================================================
package mesh_pkg;

    localparam int PCKG_SZ = 40;

    // Field bit index is pckg_sz minus the offset, so these hold for any width
    localparam int NXT_HI     = 1;
    localparam int NXT_LO     = 8;
    localparam int ROW_HI     = 9;
    localparam int ROW_LO     = 12;
    localparam int COL_HI     = 13;
    localparam int COL_LO     = 16;
    localparam int MODE_BIT   = 17;
    localparam int PAYLOAD_HI = 18;

    typedef struct packed {
        logic [7:0]              nxtjmp;
        logic [3:0]              row;
        logic [3:0]              colum;
        logic                    mode;
        logic [PCKG_SZ-18:0]     payload;
    } pkt_t;

    // Rows/columns 0 and N+1 are the edge terminals, so N+1 is still legal
    function automatic logic dest_ok(input logic [3:0] row, input logic [3:0] col,
                                     input int rows, input int colums);
        return (int'(row) <= rows + 1) && (int'(col) <= colums + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mesh_sync_fifo
// Description : Show-ahead synchronous FIFO, any depth >= 2, registered
//               count and full flag; storage is not cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] c_last = PW'(DEPTH - 1);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q;
    logic             w_rd;
    logic             w_wr;

    assign w_rd = rd_en_i && (count_q != '0);
    assign w_wr = wr_en_i && (!full_q || w_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Explicit compare keeps non-power-of-two depths wrapping correctly
        if (w_wr) wr_ptr_d = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + 1'b1;
        if (w_rd) rd_ptr_d = (rd_ptr_q == c_last) ? '0 : rd_ptr_q + 1'b1;
        if (w_wr && !w_rd)      count_d = count_q + 1'b1;
        else if (w_rd && !w_wr) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == c_depth);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !rst) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = full_q;
    assign empty_o   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mesh_term_src_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mesh_term_src_fifo
// Description : Terminal ingress buffer: screens destinations, clears Nxtjmp,
//               queues packets and counts overflow and bad-address drops.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_term_src_fifo
    import mesh_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [pckg_sz-1:0]              data_in,
    output logic                            full,
    output logic                            pndng_i_in,
    output logic [pckg_sz-1:0]              data_out_i_in,
    input  logic                            popin,
    output logic [$clog2(fifo_depth+1)-1:0] count,
    output logic                            ovf,
    output logic [7:0]                      drop_cnt,
    output logic [7:0]                      bad_cnt
);
    localparam int CW = $clog2(fifo_depth + 1);

    logic [pckg_sz-1:0] w_stamped;
    logic [pckg_sz-1:0] w_head;
    logic [CW-1:0]      w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_good;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;
    logic               w_bad;
    logic               ovf_q, ovf_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic [7:0]         bad_cnt_q, bad_cnt_d;

    assign w_good = dest_ok(data_in[pckg_sz-ROW_HI : pckg_sz-ROW_LO],
                            data_in[pckg_sz-COL_HI : pckg_sz-COL_LO], ROWS, COLUMS);
    assign w_pop  = popin && !w_empty;
    assign w_wr   = push && w_good && (!w_full || w_pop);
    assign w_drop = push && w_good && w_full && !w_pop;
    assign w_bad  = push && !w_good;

    always_comb begin
        w_stamped = data_in;
        w_stamped[pckg_sz-NXT_HI : pckg_sz-NXT_LO] = '0;
    end

    always_comb begin
        ovf_d      = ovf_q | w_drop;
        drop_cnt_d = drop_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (w_drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        if (w_bad && bad_cnt_q != 8'hFF)   bad_cnt_d  = bad_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    mesh_sync_fifo #(
        .WIDTH (pckg_sz),
        .DEPTH (fifo_depth),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (w_wr),
        .wr_data_i (w_stamped),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .count_o   (w_count),
        .full_o    (w_full),
        .empty_o   (w_empty)
    );

    // Unwritten storage may hold stale data, so hide the head when empty
    assign pndng_i_in    = !w_empty;
    assign data_out_i_in = w_empty ? '0 : w_head;
    assign full          = w_full;
    assign count         = w_count;
    assign ovf           = ovf_q;
    assign drop_cnt      = drop_cnt_q;
    assign bad_cnt       = bad_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mesh_term_src_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_term_src_fifo
// Description : Directed self-checking bench with an expected-packet queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_term_src_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push = 1'b0;
    logic        popin = 1'b0;
    logic [39:0] data_in = '0;
    logic        full;
    logic        pndng_i_in;
    logic [39:0] data_out_i_in;
    logic [2:0]  count;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic [7:0]  bad_cnt;

    int          tests = 0;
    int          fails = 0;
    logic [39:0] sb[$];
    int          m_drop = 0;
    int          m_bad  = 0;
    logic        m_ovf  = 1'b0;

    mesh_term_src_fifo #(
        .ROWS       (4),
        .COLUMS     (4),
        .pckg_sz    (40),
        .fifo_depth (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .data_in       (data_in),
        .full          (full),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .popin         (popin),
        .count         (count),
        .ovf           (ovf),
        .drop_cnt      (drop_cnt),
        .bad_cnt       (bad_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] mk(input logic [7:0] n, input logic [3:0] r,
                                       input logic [3:0] c, input logic m,
                                       input logic [22:0] p);
        return {n, r, c, m, p};
    endfunction

    function automatic logic [39:0] stamp(input logic [39:0] d);
        logic [39:0] t;
        t = d;
        t[39:32] = 8'h00;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        logic [39:0] head;
        head = (sb.size() > 0) ? sb[0] : 40'h0;
        chk("count", 64'(count), 64'(sb.size()));
        chk("full", 64'(full), 64'(sb.size() == 4));
        chk("pndng", 64'(pndng_i_in), 64'(sb.size() > 0));
        chk("head", 64'(data_out_i_in), 64'(head));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("bad_cnt", 64'(bad_cnt), 64'(m_bad));
    endtask

    task automatic cycle(input logic p, input logic [39:0] d, input logic q);
        logic good;
        bit   pop_ok;
        int   sz;
        good   = (d[31:28] <= 4'd5) && (d[27:24] <= 4'd5);
        sz     = sb.size();
        pop_ok = q && (sz > 0);
        push    = p;
        data_in = d;
        popin   = q;
        if (pop_ok) begin
            chk("pop_head", 64'(data_out_i_in), 64'(sb[0]));
            sb.delete(0);
        end
        if (p) begin
            if (!good) begin
                if (m_bad < 255) m_bad++;
            end else if (sz < 4 || pop_ok) begin
                sb.push_back(stamp(d));
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        @(posedge clk);
        #1;
        push    = 1'b0;
        popin   = 1'b0;
        data_in = '0;
        chk_all();
    endtask

    task automatic do_reset(input int n, input logic p, input logic [39:0] d);
        reset   = 1'b1;
        push    = p;
        data_in = d;
        repeat (n) @(posedge clk);
        #1;
        reset   = 1'b0;
        push    = 1'b0;
        data_in = '0;
        sb.delete();
        m_drop = 0;
        m_bad  = 0;
        m_ovf  = 1'b0;
        chk_all();
    endtask

    initial begin
        do_reset(3, 1'b0, 40'h0);
        repeat (5) cycle(1'b0, 40'h0, 1'b0);

        cycle(1'b1, mk(8'hAA, 4'd2, 4'd0, 1'b1, 23'd1), 1'b0);
        chk("stamp_nxt", 64'(data_out_i_in[39:32]), 64'h0);
        chk("stamp_rest", 64'(data_out_i_in[31:0]), 64'h2080_0001);
        cycle(1'b0, 40'h0, 1'b1);

        for (int i = 1; i <= 5; i++)
            cycle(1'b1, mk(8'h10 + 8'(i), 4'(i % 5), 4'((i * 3) % 5), 1'(i), 23'(i)), 1'b0);
        chk("drop_after_fill", 64'(drop_cnt), 64'd1);
        repeat (4) cycle(1'b0, 40'h0, 1'b1);

        cycle(1'b1, mk(8'h00, 4'd6, 4'd1, 1'b0, 23'h77), 1'b0);

        for (int i = 6; i <= 9; i++)
            cycle(1'b1, mk(8'h20 + 8'(i), 4'(i % 6), 4'(i % 4), 1'(i), 23'(i * 7)), 1'b0);
        for (int i = 10; i <= 15; i++)
            cycle(1'b1, mk(8'h30 + 8'(i), 4'(i % 6), 4'(i % 5), 1'(i), 23'(i * 13)), 1'b1);

        cycle(1'b1, mk(8'h00, 4'd6, 4'd0, 1'b0, 23'd5), 1'b0);
        chk("bad_while_full", 64'(bad_cnt), 64'd2);
        repeat (4) cycle(1'b0, 40'h0, 1'b1);
        cycle(1'b0, 40'h0, 1'b1);

        for (int i = 0; i < 3; i++)
            cycle(1'b1, mk(8'h55, 4'(i + 1), 4'd5, 1'b0, 23'(100 + i)), 1'b0);
        do_reset(1, 1'b1, mk(8'h66, 4'd1, 4'd1, 1'b1, 23'h1234));
        cycle(1'b0, 40'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mesh_term_src_fifo.md
# mesh_term_src_fifo

Terminal-side ingress buffer that feeds one edge terminal of the `mesh_gnrtr` router mesh. It accepts packets from a local producer and screens their destination fields. Accepted packets are queued in a show-ahead FIFO and presented to the mesh on the `pndng_i_in` / `data_out_i_in` / `popin` handshake. One instance sits in front of each of the `ROWS*2+COLUMS*2` terminal ports and replaces the behavioural input FIFO used by the bench drivers.

## Interface
- `ROWS`, 4, mesh rows
- `COLUMS`, 4, mesh columns
- `pckg_sz`, 40, packet width; layout `[pckg_sz-1:pckg_sz-8]` Nxtjmp, `[pckg_sz-9:pckg_sz-12]` row, `[pckg_sz-13:pckg_sz-16]` colum, `[pckg_sz-17]` mode, `[pckg_sz-18:0]` payload
- `fifo_depth`, 4, entries; any value ≥2, need not be a power of two
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `push`  in  1  producer write strobe
- `data_in`  in  pckg_sz  producer packet
- `full`  out  1  FIFO holds `fifo_depth` entries
- `pndng_i_in`  out  1  head entry valid, to mesh
- `data_out_i_in`  out  pckg_sz  head entry, to mesh
- `popin`  in  1  mesh consumes head entry
- `count`  out  $clog2(fifo_depth+1)  current occupancy
- `ovf`  out  1  sticky: a push was dropped because the FIFO was full
- `drop_cnt`  out  8  pushes dropped because the FIFO was full, saturating at 255
- `bad_cnt`  out  8  pushes rejected for bad address, saturating at 255

## Operation
- **Address screen on push.** A packet is bad if row > ROWS+1 or colum > COLUMS+1.
  - Bad packets are never written.
  - `bad_cnt` increments, even when the FIFO is also full.
  - A bad-address reject does not count toward `drop_cnt`.
- **Nxtjmp normalisation.** On every write, field Nxtjmp is forced to 8'h00. All other fields are stored unchanged.
- **Write accept.** A write happens when `push` is high, the packet is good, and either not full or `popin` is high with count>0 in the same cycle.
- **Full-drop.** A push of a good packet while full without a same-cycle pop is dropped: `ovf` sets, `drop_cnt` increments.
- **Read.** `popin` with count>0 advances the read pointer. `popin` with count==0 is ignored: no error, counters unchanged.
- **Simultaneous push+pop.** Count is unchanged and both pointers advance. This holds when full. When empty, the pop is ignored and only the push takes effect.
- **Pointer wrap.** Pointers wrap from `fifo_depth-1` to 0 by explicit compare, with no modulo-2^n assumption.
- **Counter saturation.** `drop_cnt` and `bad_cnt` hold at 255. `ovf` clears only on reset.

## Timing
- **Reset.** Applies at the first rising edge with `reset` high. Outputs then read:
  - `count`=0, `full`=0, `pndng_i_in`=0, `data_out_i_in`='0
  - `ovf`=0, `drop_cnt`=0, `bad_cnt`=0
  - Storage contents are not cleared.
- **Reset mid-operation.** Queued packets are discarded. A `push` or `popin` in the reset cycle is ignored.
- **Push latency.** A push accepted at edge N into an empty FIFO gives `pndng_i_in`=1 and `data_out_i_in`=packet after edge N.
- **Show-ahead head.** `data_out_i_in` always equals the head entry when count>0, and is driven '0 when count==0 (combinational from registered state).
- **Pop latency.** `popin` sampled at edge N removes the head, and the next entry appears after edge N. `pndng_i_in` drops after edge N if that was the last entry.
- **Registered flags.** `full`, `count`, `ovf` and the counters are registered and update after the causing edge.
- **No combinational paths.** Nothing goes from `push` or `popin` to any output.

## Structure
- **Shared package `mesh_pkg`.**
  - Field offset localparams: NXT_HI/LO, ROW_HI/LO, COL_HI/LO, MODE_BIT, PAYLOAD_HI.
  - Packet struct typedef parameterised via `pckg_sz`.
  - The address-check function `dest_ok(row, col, ROWS, COLUMS)`.
  - The router wrapper and bench reuse the same package.
- **Sub-module `mesh_sync_fifo`.** Plain storage with pointers, count and full/empty. It is instantiated here.
- **Top-level logic.** Screening, Nxtjmp stamping, drop/bad accounting and output zeroing live in this module.

## Test plan
- **Reset/idle.** Reset 3 cycles, then idle 5 cycles -> all outputs 0, `data_out_i_in`=0.
- **Nxtjmp stamping.** Push one packet with Nxtjmp=8'hAA, row=2, colum=0, mode=1, payload=1 -> next cycle `pndng_i_in`=1 and `data_out_i_in` has Nxtjmp=0 with other fields intact. `popin` 1 cycle -> `pndng_i_in`=0, `count`=0.
- **Fill and overflow.** Push 5 good packets back-to-back, no pops, depth 4 -> `full`=1 after the 4th, 5th dropped, `ovf`=1, `drop_cnt`=1. Pops return packets 1–4 in order.
- **Push+pop when full.** Hold full, then push+pop in the same cycle for 6 cycles -> `count` stays 4, `drop_cnt` unchanged, order preserved across pointer wrap.
- **Bad address.** Push row=6 with ROWS=4 -> not stored, `bad_cnt`=1, `pndng_i_in` stays 0. Repeat while full -> `bad_cnt`=2, `drop_cnt` unchanged.
- **Empty pop and mid-stream reset.** `popin` while empty -> no change. Reset asserted with 3 entries queued -> next cycle `count`=0, `pndng_i_in`=0, and a `push` in the reset cycle is not stored.
